// File: rtl/activation_addr_gen.sv
// Converts per-neuron signed accumulator sums into saturated activation LUT
// addresses, one neuron slot at a time, through a two-stage issue/write pipe.
module activation_addr_gen #(
    parameter int max_neurons   = 8,
    parameter int sum_width     = 24,
    parameter int lut_addr_size = 10,
    parameter int sum_shift     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [$clog2(max_neurons):0]         neuron_count,
    input  logic [sum_width*max_neurons-1:0]     sums,
    input  logic [max_neurons-1:0]               sums_valid,
    output logic [lut_addr_size*max_neurons-1:0] addr,
    output logic [max_neurons-1:0]               valid_addr,
    output logic                                 busy,
    output logic                                 done
);

    localparam int CW = $clog2(max_neurons) + 1;
    localparam int PW = (max_neurons > 1) ? $clog2(max_neurons) : 1;
    localparam logic signed [sum_width:0] OFFSET = (sum_width + 1)'(2 ** (lut_addr_size - 1));
    localparam logic signed [sum_width:0] MAXA   = (sum_width + 1)'(2 ** lut_addr_size - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                        state, next_state;
    logic [CW-1:0]                 n_reg, n_start;
    logic [PW-1:0]                 pos;
    logic [max_neurons-1:0]        pending, active_mask;
    logic                          s1_valid;
    logic signed [sum_width-1:0]   s1_sum;
    logic [PW-1:0]                 s1_pos;
    logic                          issue, all_written;
    logic signed [sum_width:0]     s_ext, a_full;
    logic [lut_addr_size-1:0]      a_sat;

    assign n_start = (neuron_count > CW'(max_neurons)) ? CW'(max_neurons) : neuron_count;

    always_comb begin
        active_mask = '0;
        for (int i = 0; i < max_neurons; i++)
            active_mask[i] = (CW'(i) < n_reg);
    end

    assign issue       = (state == SCAN) && sums_valid[pos] && !valid_addr[pos] && !pending[pos];
    assign all_written = ((valid_addr & active_mask) == active_mask);

    // Saturating conversion at one extra bit of precision so the offset never wraps
    always_comb begin
        s_ext  = {s1_sum[sum_width-1], s1_sum};
        a_full = (s_ext >>> sum_shift) + OFFSET;
        if (a_full[sum_width])
            a_sat = '0;
        else if (a_full > MAXA)
            a_sat = '1;
        else
            a_sat = a_full[lut_addr_size-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // start overrides everything; an empty layer completes immediately
    always_comb begin
        next_state = state;
        busy       = (state == SCAN);
        done       = (state == DONE);
        if (start)
            next_state = (n_start == '0) ? DONE : SCAN;
        else if (state == SCAN && all_written)
            next_state = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            valid_addr <= '0;
            pending    <= '0;
            s1_valid   <= 1'b0;
            s1_sum     <= '0;
            s1_pos     <= '0;
            pos        <= '0;
            n_reg      <= '0;
        end else if (start) begin
            valid_addr <= '0;
            pending    <= '0;
            s1_valid   <= 1'b0;
            pos        <= '0;
            n_reg      <= n_start;
        end else begin
            if (s1_valid) begin
                addr[s1_pos*lut_addr_size +: lut_addr_size] <= a_sat;
                valid_addr[s1_pos] <= 1'b1;
                pending[s1_pos]    <= 1'b0;
            end
            s1_valid <= issue;
            if (issue) begin
                s1_sum       <= sums[pos*sum_width +: sum_width];
                s1_pos       <= pos;
                pending[pos] <= 1'b1;
            end
            if (state == SCAN)
                pos <= (pos == PW'(n_reg - CW'(1))) ? '0 : pos + PW'(1);
        end
    end

endmodule

// File: tb/tb_activation_addr_gen.sv
// Directed bench for activation_addr_gen: conversion, saturation, incremental
// sums_valid, empty/oversized layers, restart and reset mid-pass.
module tb_activation_addr_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   neuron_count;
    logic [191:0] sums;
    logic [7:0]   sums_valid;
    logic [79:0]  addr;
    logic [7:0]   valid_addr;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int cyc;

    activation_addr_gen dut (
        .clk(clk), .rst(rst), .start(start), .neuron_count(neuron_count),
        .sums(sums), .sums_valid(sums_valid), .addr(addr),
        .valid_addr(valid_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setSum(input int i, input int val);
        sums[i*24 +: 24] = 24'(val);
    endtask

    function automatic logic [9:0] slotAddr(input int i);
        return addr[i*10 +: 10];
    endfunction

    task automatic applyStimulus(input logic [3:0] n, input logic [7:0] sv);
        neuron_count = n;
        sums_valid   = sv;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic waitBit(input int idx, input int budget, output int cycles);
        cycles = 0;
        while (!valid_addr[idx] && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; neuron_count = '0; sums = '0; sums_valid = '0;
        tick(); tick();
        rst = 1'b0;
        checkOutput("reset_addr", 32'(addr == '0), 1);
        checkOutput("reset_valid", 32'(valid_addr), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);

        // basic conversion, n=4
        setSum(0, 0); setSum(1, 256); setSum(2, -256); setSum(3, 1000000);
        applyStimulus(4'd4, 8'h0F);
        checkOutput("t1_busy", 32'(busy), 1);
        waitDone(8, cyc);
        checkOutput("t1_done", 32'(done), 1);
        checkOutput("t1_a0", 32'(slotAddr(0)), 512);
        checkOutput("t1_a1", 32'(slotAddr(1)), 513);
        checkOutput("t1_a2", 32'(slotAddr(2)), 511);
        checkOutput("t1_a3", 32'(slotAddr(3)), 1023);
        checkOutput("t1_valid", 32'(valid_addr), 32'h0F);
        checkOutput("t1_busy_off", 32'(busy), 0);
        checkOutput("t1_a4_unused", 32'(slotAddr(4)), 0);

        // saturation boundaries, n=8
        setSum(0, -(1 << 23)); setSum(1, (1 << 23) - 1); setSum(2, -131072);
        setSum(3, -130816); setSum(4, 130816); setSum(5, 131072);
        setSum(6, -1); setSum(7, 255);
        applyStimulus(4'd8, 8'hFF);
        waitDone(12, cyc);
        checkOutput("t2_done", 32'(done), 1);
        checkOutput("t2_min", 32'(slotAddr(0)), 0);
        checkOutput("t2_max", 32'(slotAddr(1)), 1023);
        checkOutput("t2_lo_edge", 32'(slotAddr(2)), 0);
        checkOutput("t2_lo_in", 32'(slotAddr(3)), 1);
        checkOutput("t2_hi_in", 32'(slotAddr(4)), 1023);
        checkOutput("t2_hi_edge", 32'(slotAddr(5)), 1023);
        checkOutput("t2_neg1", 32'(slotAddr(6)), 511);
        checkOutput("t2_255", 32'(slotAddr(7)), 512);

        // incremental sums_valid, n=3, one-hot so earlier bits drop after issue
        setSum(0, 0); setSum(1, 768); setSum(2, -768);
        applyStimulus(4'd3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            sums_valid = 8'(1 << i);
            waitBit(i, 5, cyc);
            checkOutput($sformatf("t3_lat%0d", i), 32'(valid_addr[i]), 1);
            checkOutput($sformatf("t3_vmask%0d", i), 32'(valid_addr), 32'((1 << (i + 1)) - 1));
            if (i < 2) checkOutput($sformatf("t3_notdone%0d", i), 32'(done), 0);
            for (int k = cyc; k < 5; k++) tick();
        end
        checkOutput("t3_done", 32'(done), 1);
        checkOutput("t3_a1", 32'(slotAddr(1)), 515);
        checkOutput("t3_a2", 32'(slotAddr(2)), 509);

        // empty layer and oversized count
        applyStimulus(4'd0, 8'hFF);
        checkOutput("t4_n0_done", 32'(done), 1);
        checkOutput("t4_n0_busy", 32'(busy), 0);
        checkOutput("t4_n0_valid", 32'(valid_addr), 0);
        setSum(7, 2560);
        applyStimulus(4'd12, 8'hFF);
        checkOutput("t4_n12_busy", 32'(busy), 1);
        waitDone(12, cyc);
        checkOutput("t4_n12_done", 32'(done), 1);
        checkOutput("t4_n12_valid", 32'(valid_addr), 32'hFF);
        checkOutput("t4_n12_a7", 32'(slotAddr(7)), 522);

        // restart mid-pass while slot 2 is in flight
        setSum(0, 256); setSum(1, 256); setSum(2, 256);
        applyStimulus(4'd4, 8'h07);
        waitBit(1, 8, cyc);
        checkOutput("t5_two", 32'(valid_addr), 32'h03);
        sums_valid = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t5_cleared", 32'(valid_addr), 0);
        checkOutput("t5_busy", 32'(busy), 1);
        repeat (4) tick();
        checkOutput("t5_no_stale", 32'(valid_addr), 0);
        setSum(2, -2560);
        sums_valid = 8'h04;
        waitBit(2, 6, cyc);
        checkOutput("t5_new_valid", 32'(valid_addr), 32'h04);
        checkOutput("t5_new_a2", 32'(slotAddr(2)), 502);

        // reset during a stage-2 write
        applyStimulus(4'd4, 8'h0F);
        waitBit(0, 6, cyc);
        checkOutput("t6_slot0", 32'(valid_addr[0]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_addr", 32'(addr == '0), 1);
        checkOutput("t6_valid", 32'(valid_addr), 0);
        checkOutput("t6_busy", 32'(busy), 0);
        checkOutput("t6_done", 32'(done), 0);
        repeat (3) tick();
        checkOutput("t6_idle_valid", 32'(valid_addr), 0);
        checkOutput("t6_idle_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
